fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 34 +++
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - Fetch stage bus: decode control, instruction memory and IF/ID outputs
//
// Purpose: bundles every non-clock signal of fetch_stage.
// Signals:
//   stall            decode cannot accept; hold PC and IF/ID
//   redirect_valid   branch/jump taken
//   redirect_target  byte address of the next instruction (low two bits ignored)
//   imem_addr        byte address to instruction memory (current PC)
//   imem_data        combinational instruction word for imem_addr
//   id_valid         IF/ID holds a real instruction
//   id_pc            address of id_ins
//   id_ins           registered instruction word for decode
// Modports: master = fetch stage, slave = pipeline/memory side.

interface fetch_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_ins;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_data,
    output imem_addr, id_valid, id_pc, id_ins
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_data,
    input  imem_addr, id_valid, id_pc, id_ins
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Instruction fetch stage with PC register and IF/ID pipeline register
//
// Purpose: drives the PC onto instruction memory, captures the returned word
// into the IF/ID register, and handles stall, redirect and reset.
// Parameters:
//   RESET_PC  PC value loaded on reset
//   NOP_INS   bubble word placed in IF/ID on reset or redirect
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          fetch_stage_if.master (see rtl/fetch_stage_if.sv)
//   fetch_count  accepted fetches   (only with FETCH_PERF_EN defined)
//   stall_count  stalled cycles     (only with FETCH_PERF_EN defined)
// Optional feature macro: FETCH_PERF_EN adds the two performance counters.

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INS  = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  // RUN: IF/ID holds a real instruction. FLUSH: IF/ID holds a bubble.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q;
  logic [31:0] id_ins_q;
  logic        fetch_ok;

  assign bus.imem_addr = pc_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_ins    = id_ins_q;
  // id_valid comes straight from the state register, so it has no
  // combinational dependence on any input.
  assign bus.id_valid  = (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fetch_ok = 1'b0;
    if (bus.redirect_valid) begin
      // Redirect wins over stall; the target is forced to word alignment.
      state_d = FLUSH;
      pc_d    = bus.redirect_target & ~32'd3;
    end else if (!bus.stall) begin
      state_d  = RUN;
      fetch_ok = 1'b1;
      pc_d     = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FLUSH;
      pc_q     <= RESET_PC;
      id_pc_q  <= 32'h00000000;
      id_ins_q <= NOP_INS;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (bus.redirect_valid) begin
        id_ins_q <= NOP_INS;
      end else if (fetch_ok) begin
        id_ins_q <= bus.imem_data;
        id_pc_q  <= pc_q;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 32'h00000000;
      stall_count <= 32'h00000000;
    end else begin
      if (fetch_ok) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (bus.stall && !bus.redirect_valid) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - Self-checking bench for fetch_stage

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  logic [31:0] mem [64];
  assign bus.imem_data = mem[bus.imem_addr[7:2]];

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
  fetch_stage dut (
    .clk(clk), .rst(rst), .bus(bus.master),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );
`else
  fetch_stage dut (.clk(clk), .rst(rst), .bus(bus.master));
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: what the pipeline should look like after each edge.
  logic [31:0] m_pc, m_ipc, m_ins;
  logic        m_v;
  logic [31:0] m_fc, m_sc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs across one rising edge, advance the model, compare.
  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] t);
    rst                 = r;
    bus.stall           = s;
    bus.redirect_valid  = rv;
    bus.redirect_target = t;
    if (r) begin
      m_pc = 32'h0; m_v = 1'b0; m_ipc = 32'h0; m_ins = NOP; m_fc = 0; m_sc = 0;
    end else if (rv) begin
      m_pc = {t[31:2], 2'b00}; m_v = 1'b0; m_ins = NOP;
    end else if (s) begin
      m_sc = m_sc + 1;
    end else begin
      m_ins = mem[m_pc[7:2]]; m_ipc = m_pc; m_v = 1'b1; m_pc = m_pc + 4; m_fc = m_fc + 1;
    end
    @(posedge clk);
    #1;
    chk("model_imem_addr", bus.imem_addr, m_pc);
    chk("model_id_valid", {31'b0, bus.id_valid}, {31'b0, m_v});
    chk("model_id_pc", bus.id_pc, m_ipc);
    chk("model_id_ins", bus.id_ins, m_ins);
`ifdef FETCH_PERF_EN
    chk("model_fetch_count", fetch_count, m_fc);
    chk("model_stall_count", stall_count, m_sc);
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h03700093;
    mem[1] = NOP;
    mem[2] = NOP;
    mem[3] = NOP;
    mem[4] = 32'h00408093;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;

    // Reset held for two cycles, then first fetch.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
    chk("rst_id_ins", bus.id_ins, 32'h00000013);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    step(0, 0, 0, 0);
    chk("first_id_ins", bus.id_ins, 32'h03700093);
    chk("first_id_pc", bus.id_pc, 32'h0);
    chk("first_id_valid", {31'b0, bus.id_valid}, 32'd1);

    // Sequential fetch continues to address 16.
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0);
      chk("seq_id_pc", bus.id_pc, 32'(k * 4));
    end
    chk("seq_id_ins_16", bus.id_ins, 32'h00408093);

    // Stall with id_pc = 8.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0);
      chk("stall_id_pc", bus.id_pc, 32'd8);
      chk("stall_imem_addr", bus.imem_addr, 32'd12);
      chk("stall_id_valid", {31'b0, bus.id_valid}, 32'd1);
    end
    step(0, 0, 0, 0);
    chk("unstall_id_pc", bus.id_pc, 32'd12);

    // Redirect to an unaligned target while stalled.
    step(0, 1, 1, 32'h00000012);
    chk("redir_imem_addr", bus.imem_addr, 32'd16);
    chk("redir_id_valid", {31'b0, bus.id_valid}, 32'd0);
    chk("redir_id_pc_hold", bus.id_pc, 32'd12);
    chk("redir_id_ins", bus.id_ins, NOP);
    step(0, 0, 0, 0);
    chk("redir_tgt_id_pc", bus.id_pc, 32'd16);
    chk("redir_tgt_id_ins", bus.id_ins, 32'h00408093);
    chk("redir_tgt_valid", {31'b0, bus.id_valid}, 32'd1);

    // PC wrap, then reset together with redirect.
    step(0, 0, 1, 32'hFFFFFFFC);
    step(0, 0, 0, 0);
    chk("wrap_imem_addr", bus.imem_addr, 32'h0);
    chk("wrap_id_pc", bus.id_pc, 32'hFFFFFFFC);
    step(1, 1, 1, 32'h00000040);
    chk("rst_redir_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_redir_id_valid", {31'b0, bus.id_valid}, 32'd0);

`ifdef FETCH_PERF_EN
    chk("perf_fc_rst", fetch_count, 32'd0);
    chk("perf_sc_rst", stall_count, 32'd0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h8);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("perf_fc", fetch_count, 32'd4);
    chk("perf_sc", stall_count, 32'd2);
    step(1, 0, 0, 0);
    chk("perf_fc_after_rst", fetch_count, 32'd0);
    chk("perf_sc_after_rst", stall_count, 32'd0);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic r, s, rv;
      logic [31:0] t;
      r  = ($urandom_range(0, 31) == 0);
      rv = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 3) == 0);
      t  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFF);
      step(r, s, rv, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
